booth_multiplier_seq: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier for the arithmetic processor datapath.
- Successor to the fixed 8-bit multiplier. Adds the following:
  - configurable operand width;
  - a per-operation signed/unsigned mode;
  - synchronous reset;
  - an explicit Start/Busy/Done handshake;
  - a registered Product that stays stable while a new operation runs.
- Sits beside the ALU as a multi-cycle functional unit driven by the control FSM.

---
 rtl/booth_multiplier_seq.sv | 93 +++++++++
 tb/tb_booth_multiplier_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with Start/Busy/Done handshake.
// Operands are extended to WIDTH+1 bits so one datapath serves signed and unsigned modes.
module booth_multiplier_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Signed,
  input  logic [WIDTH-1:0]       Multiplicand,
  input  logic [WIDTH-1:0]       Multiplier,
  output logic [2*WIDTH-1:0]     Product,
  output logic                   Busy,
  output logic                   Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t           state, state_next;
  logic [WIDTH:0]   a_r, m_r, q_r;
  logic             q1_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH:0]   sum, a_nxt, q_nxt;
  logic             load, last;

  always_comb begin
    load = Start && ((state == IDLE) || (state == DONE));
    last = (state == RUN) && (count_r == LAST_CNT);
  end

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Booth step followed by an arithmetic right shift of {A,Q,Q_1}.
  always_comb begin
    case ({q_r[0], q1_r})
      2'b01:   sum = a_r + m_r;
      2'b10:   sum = a_r - m_r;
      default: sum = a_r;
    endcase
    a_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt = {sum[0], q_r[WIDTH:1]};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      a_r     <= '0;
      m_r     <= '0;
      q_r     <= '0;
      q1_r    <= 1'b0;
      count_r <= '0;
      Product <= '0;
    end else if (load) begin
      a_r     <= '0;
      m_r     <= {Signed & Multiplicand[WIDTH-1], Multiplicand};
      q_r     <= {Signed & Multiplier[WIDTH-1], Multiplier};
      q1_r    <= 1'b0;
      count_r <= '0;
    end else if (state == RUN) begin
      a_r     <= a_nxt;
      q_r     <= q_nxt;
      q1_r    <= q_r[0];
      count_r <= count_r + 1'b1;
      // Low 2*WIDTH bits of the final shifted {A,Q}; upper bits only carry sign.
      if (last) Product <= {a_nxt[WIDTH-2:0], q_nxt};
    end
  end

  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq: 8-bit scenarios plus an exhaustive 4-bit sweep.
module tb_booth_multiplier_seq;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        start8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;
  logic        start4 = 1'b0, signed4 = 1'b0;
  logic [3:0]  m4 = '0, q4 = '0;
  logic [7:0]  p4;
  logic        busy4, done4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .Reset(Reset), .Start(start8), .Signed(signed8),
    .Multiplicand(m8), .Multiplier(q8), .Product(p8), .Busy(busy8), .Done(done8)
  );

  booth_multiplier_seq #(.WIDTH(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .Start(start4), .Signed(signed4),
    .Multiplicand(m4), .Multiplier(q4), .Product(p4), .Busy(busy4), .Done(done4)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic launch8(input logic s, input logic [7:0] m, input logic [7:0] q);
    start8 = 1'b1; signed8 = s; m8 = m; q8 = q;
    tick();
    start8 = 1'b0; m8 = 8'hA5; q8 = 8'h5A; signed8 = ~s;
  endtask

  task automatic launch4(input logic s, input logic [3:0] m, input logic [3:0] q);
    start4 = 1'b1; signed4 = s; m4 = m; q4 = q;
    tick();
    start4 = 1'b0; m4 = 4'h9; q4 = 4'h6; signed4 = ~s;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin tick(); n++; end
    if (done8 !== 1'b1) n = -1;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (done4 !== 1'b1 && n < 100) begin tick(); n++; end
    if (done4 !== 1'b1) n = -1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; start8 = 1'b1; signed8 = 1'b1; m8 = 8'hFD; q8 = 8'h05;
    tick(); tick();
    Reset = 1'b0; start8 = 1'b0;
    checks++;
    if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h want=0000", p8); end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b want 0/0", busy8, done8);
    end
    tick();
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_start_dropped got busy=%b want 0", busy8); end
  endtask

  task automatic test_signed_basic;
    int n;
    launch8(1'b1, 8'hFD, 8'h05);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || p8 !== 16'h0000) begin
        errors++;
        $display("FAIL signed_running cycle=%0d got busy=%b done=%b prod=%h want 1/0/0000", i + 1, busy8, done8, p8);
      end
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++; $display("FAIL signed_done_pulse got done=%b busy=%b want 1/0", done8, busy8);
    end
    checks++;
    if (p8 !== 16'hFFF1) begin errors++; $display("FAIL signed_m3x5 got=%h want=fff1", p8); end
    tick();
    checks++;
    if (done8 !== 1'b0 || p8 !== 16'hFFF1) begin
      errors++; $display("FAIL signed_after_done got done=%b prod=%h want 0/fff1", done8, p8);
    end
    launch8(1'b1, 8'h80, 8'h80);
    wait_done8(n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL min_min_latency got=%0d want=9", n); end
    checks++;
    if (p8 !== 16'h4000) begin errors++; $display("FAIL min_min got=%h want=4000", p8); end
  endtask

  task automatic test_modes;
    int n;
    tick();
    launch8(1'b0, 8'hFF, 8'hFF);
    wait_done8(n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL unsigned_latency got=%0d want=9", n); end
    checks++;
    if (p8 !== 16'hFE01) begin errors++; $display("FAIL unsigned_ffxff got=%h want=fe01", p8); end
    launch8(1'b1, 8'hFF, 8'hFF);
    wait_done8(n);
    checks++;
    if (p8 !== 16'h0001) begin errors++; $display("FAIL signed_m1xm1 got=%h want=0001", p8); end
  endtask

  task automatic test_ignore_start;
    int n;
    tick();
    launch8(1'b1, 8'hFD, 8'h05);
    tick(); tick();
    start8 = 1'b1; signed8 = 1'b1; m8 = 8'h07; q8 = 8'h07;
    tick();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b want=1", busy8); end
    wait_done8(n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL ignore_latency got=%0d want=6", n); end
    checks++;
    if (p8 !== 16'hFFF1) begin errors++; $display("FAIL ignore_product got=%h want=fff1", p8); end
    tick();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL ignore_no_extra got done=%b busy=%b want 0/0", done8, busy8);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    launch8(1'b1, 8'hFD, 8'h05);
    wait_done8(n);
    checks++;
    if (p8 !== 16'hFFF1) begin errors++; $display("FAIL b2b_first got=%h want=fff1", p8); end
    start8 = 1'b1; signed8 = 1'b1; m8 = 8'h02; q8 = 8'h03;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (busy8 !== 1'b1 || p8 !== 16'hFFF1) begin
        errors++; $display("FAIL b2b_hold cycle=%0d got busy=%b prod=%h want 1/fff1", i + 1, busy8, p8);
      end
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || p8 !== 16'h0006) begin
      errors++; $display("FAIL b2b_second got done=%b prod=%h want 1/0006", done8, p8);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    tick();
    launch8(1'b1, 8'hFD, 8'h05);
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0000) begin
      errors++; $display("FAIL abort_state got busy=%b done=%b prod=%h want 0/0/0000", busy8, done8, p8);
    end
    launch8(1'b1, 8'h02, 8'h03);
    wait_done8(n);
    checks++;
    if (n !== 9 || p8 !== 16'h0006) begin
      errors++; $display("FAIL abort_recover got cycles=%0d prod=%h want 9/0006", n, p8);
    end
  endtask

  task automatic test_exhaustive4;
    int n, av, bv;
    logic [7:0] expv;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          av = (s == 1 && a >= 8) ? a - 16 : a;
          bv = (s == 1 && b >= 8) ? b - 16 : b;
          expv = 8'(av * bv);
          launch4(s[0], 4'(a), 4'(b));
          wait_done4(n);
          checks++;
          if (n !== 5) begin errors++; $display("FAIL w4_latency s=%0d a=%0d b=%0d got=%0d want=5", s, a, b, n); end
          checks++;
          if (p4 !== expv) begin errors++; $display("FAIL w4_product s=%0d a=%0d b=%0d got=%h want=%h", s, a, b, p4, expv); end
          tick();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_modes();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
